// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : video_pkg
//  Purpose  : Shared definitions for the raster timing generator: the timing
//             mode record (eight geometry fields plus sync polarities), the
//             default 640x400 mode, and helpers that derive line/frame totals
//             and sync window bounds from a mode.
//  Revision : 1.0 - initial release
// ============================================================================
package video_pkg;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_active;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
        logic        hs_pol;
        logic        vs_pol;
    } timing_mode_t;

    // 640x400 timing used on the Colorlight DVI output.
    localparam timing_mode_t c_MODE_640X400 = '{
        h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
        v_active: 16'd400, v_fp: 16'd12, v_sync: 16'd2,  v_bp: 16'd35,
        hs_pol:   1'b0,    vs_pol: 1'b1
    };

    function automatic int mode_h_total(input timing_mode_t m);
        return int'(m.h_active) + int'(m.h_fp) + int'(m.h_sync) + int'(m.h_bp);
    endfunction

    function automatic int mode_v_total(input timing_mode_t m);
        return int'(m.v_active) + int'(m.v_fp) + int'(m.v_sync) + int'(m.v_bp);
    endfunction

    // Sync window is [start, end): it follows active video and the front porch.
    function automatic int mode_hs_start(input timing_mode_t m);
        return int'(m.h_active) + int'(m.h_fp);
    endfunction

    function automatic int mode_hs_end(input timing_mode_t m);
        return int'(m.h_active) + int'(m.h_fp) + int'(m.h_sync);
    endfunction

    function automatic int mode_vs_start(input timing_mode_t m);
        return int'(m.v_active) + int'(m.v_fp);
    endfunction

    function automatic int mode_vs_end(input timing_mode_t m);
        return int'(m.v_active) + int'(m.v_fp) + int'(m.v_sync);
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_axis_counter.sv
`default_nettype none
// ============================================================================
//  Module   : video_axis_counter
//  Purpose  : One raster axis: a 0..TOTAL-1 wrapping counter with decodes of
//             the current count (last position, active window, sync window).
//             Used once for the horizontal axis and once for the vertical axis.
//  Ports    : clk      - pixel clock
//             rst      - asynchronous active-high reset (count -> 0)
//             i_en     - advance the count by one (wraps after TOTAL-1)
//             o_cnt    - current count (the position about to be presented)
//             o_last   - count == TOTAL-1
//             o_active - count < ACTIVE
//             o_sync   - SYNC_START <= count < SYNC_END
//  Revision : 1.0 - initial release
// ============================================================================
module video_axis_counter #(
    parameter int W          = 11,
    parameter int TOTAL      = 800,
    parameter int ACTIVE     = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 752
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_last,
    output logic         o_active,
    output logic         o_sync
);

    localparam logic [W-1:0] c_LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] c_ACTIVE     = W'(ACTIVE);
    localparam logic [W-1:0] c_SYNC_START = W'(SYNC_START);
    localparam logic [W-1:0] c_SYNC_END   = W'(SYNC_END);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + W'(1);
        end
    end

    assign o_cnt    = r_cnt;
    assign o_last   = (r_cnt == c_LAST);
    assign o_active = (r_cnt < c_ACTIVE);
    assign o_sync   = (r_cnt >= c_SYNC_START) && (r_cnt < c_SYNC_END);

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : video_timing_gen
//  Purpose  : Parametrised raster timing generator in the pixel clock domain.
//             Produces hsync/vsync/data-enable, pixel coordinates, line and
//             frame strobes, an early line-fetch request and a frame counter.
//  Ports    : clk_i         - pixel clock
//             rst_i         - asynchronous active-high reset
//             ce_i          - pixel enable; everything advances only when 1
//             hs_o / vs_o   - syncs, active level set by HS_POL / VS_POL
//             de_o          - active video
//             x_o / y_o     - pixel column / row (hold outside active video)
//             line_start_o  - first pixel of each active line
//             frame_start_o - pixel (0,0)
//             fetch_o       - line-fetch request, FETCH_LEAD ce cycles ahead
//             fetch_line_o  - row (or buffer line) to fetch, with fetch_o
//             frame_o       - frame counter, mod 256
//             repeat_o      - (scan-double build only) odd active row
//  Build    : define VIDEO_TIMING_SCANDOUBLE_EN to fetch only before even rows
//             with fetch_line_o = row>>1 and to add the repeat_o output.
//  Revision : 1.0 - initial release
// ============================================================================
module video_timing_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE   = int'(c_MODE_640X400.h_active),
    parameter int H_FP       = int'(c_MODE_640X400.h_fp),
    parameter int H_SYNC     = int'(c_MODE_640X400.h_sync),
    parameter int H_BP       = int'(c_MODE_640X400.h_bp),
    parameter int V_ACTIVE   = int'(c_MODE_640X400.v_active),
    parameter int V_FP       = int'(c_MODE_640X400.v_fp),
    parameter int V_SYNC     = int'(c_MODE_640X400.v_sync),
    parameter int V_BP       = int'(c_MODE_640X400.v_bp),
    parameter int HS_POL     = int'(c_MODE_640X400.hs_pol),
    parameter int VS_POL     = int'(c_MODE_640X400.vs_pol),
    parameter int FETCH_LEAD = 32,
    parameter int XW         = 11,
    parameter int YW         = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ce_i,
    output logic          hs_o,
    output logic          vs_o,
    output logic          de_o,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          line_start_o,
    output logic          frame_start_o,
    output logic          fetch_o,
    output logic [YW-1:0] fetch_line_o,
    output logic [7:0]    frame_o
`ifdef VIDEO_TIMING_SCANDOUBLE_EN
    ,
    output logic          repeat_o
`endif
);

    localparam timing_mode_t c_MODE = '{
        h_active: 16'(H_ACTIVE), h_fp: 16'(H_FP), h_sync: 16'(H_SYNC), h_bp: 16'(H_BP),
        v_active: 16'(V_ACTIVE), v_fp: 16'(V_FP), v_sync: 16'(V_SYNC), v_bp: 16'(V_BP),
        hs_pol:   (HS_POL != 0), vs_pol: (VS_POL != 0)
    };

    localparam int c_H_TOTAL = mode_h_total(c_MODE);
    localparam int c_V_TOTAL = mode_v_total(c_MODE);

    localparam logic          c_HS_ACT   = c_MODE.hs_pol;
    localparam logic          c_VS_ACT   = c_MODE.vs_pol;
    localparam logic [XW-1:0] c_FETCH_H  = XW'(c_H_TOTAL - FETCH_LEAD);
    localparam logic [YW-1:0] c_V_ACTIVE = YW'(V_ACTIVE);

    // Counter state is the position about to be presented; the registers
    // below capture its decode on each ce edge, so the first ce edge after
    // reset presents pixel (0,0).
    logic [XW-1:0] w_h_cnt;
    logic [YW-1:0] w_v_cnt;
    logic          w_h_last, w_h_active, w_h_sync;
    logic          w_v_last, w_v_active, w_v_sync;

    video_axis_counter #(
        .W          (XW),
        .TOTAL      (c_H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (mode_hs_start(c_MODE)),
        .SYNC_END   (mode_hs_end(c_MODE))
    ) u_h_axis (
        .clk      (clk_i),
        .rst      (rst_i),
        .i_en     (ce_i),
        .o_cnt    (w_h_cnt),
        .o_last   (w_h_last),
        .o_active (w_h_active),
        .o_sync   (w_h_sync)
    );

    // Vertical axis steps once per line, on the horizontal wrap.
    video_axis_counter #(
        .W          (YW),
        .TOTAL      (c_V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (mode_vs_start(c_MODE)),
        .SYNC_END   (mode_vs_end(c_MODE))
    ) u_v_axis (
        .clk      (clk_i),
        .rst      (rst_i),
        .i_en     (ce_i && w_h_last),
        .o_cnt    (w_v_cnt),
        .o_last   (w_v_last),
        .o_active (w_v_active),
        .o_sync   (w_v_sync)
    );

    // Row that follows the current line; row 0 follows the last frame line.
    logic [YW-1:0] w_next_row;
    logic          w_fetch;
    logic [YW-1:0] w_fetch_line;
    logic          w_de;

    assign w_next_row = w_v_last ? '0 : w_v_cnt + YW'(1);
    assign w_de       = w_h_active && w_v_active;

`ifdef VIDEO_TIMING_SCANDOUBLE_EN
    // Each buffered line is shown twice: fetch only ahead of even rows.
    assign w_fetch      = (w_h_cnt == c_FETCH_H) && (w_next_row < c_V_ACTIVE) && !w_next_row[0];
    assign w_fetch_line = w_next_row >> 1;
`else
    assign w_fetch      = (w_h_cnt == c_FETCH_H) && (w_next_row < c_V_ACTIVE);
    assign w_fetch_line = w_next_row;
`endif

    logic          r_hs, r_vs, r_de, r_line_start, r_frame_start, r_fetch;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [YW-1:0] r_fetch_line;
    logic [7:0]    r_frame;
    logic          r_repeat;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hs          <= ~c_HS_ACT;
            r_vs          <= ~c_VS_ACT;
            r_de          <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_fetch       <= 1'b0;
            r_fetch_line  <= '0;
            r_frame       <= 8'd0;
            r_repeat      <= 1'b0;
        end else if (ce_i) begin
            r_hs          <= w_h_sync ? c_HS_ACT : ~c_HS_ACT;
            r_vs          <= w_v_sync ? c_VS_ACT : ~c_VS_ACT;
            r_de          <= w_de;
            r_line_start  <= w_de && (w_h_cnt == '0);
            r_frame_start <= w_de && (w_h_cnt == '0) && (w_v_cnt == '0);
            r_fetch       <= w_fetch;
            r_repeat      <= w_v_active && w_v_cnt[0];
            if (w_de) begin
                r_x <= w_h_cnt;
                r_y <= w_v_cnt;
            end
            if (w_fetch) begin
                r_fetch_line <= w_fetch_line;
            end
            // Frame counter steps on the same edge the counters wrap.
            if (w_h_last && w_v_last) begin
                r_frame <= r_frame + 8'd1;
            end
        end
    end

    assign hs_o          = r_hs;
    assign vs_o          = r_vs;
    assign de_o          = r_de;
    assign x_o           = r_x;
    assign y_o           = r_y;
    assign line_start_o  = r_line_start;
    assign frame_start_o = r_frame_start;
    assign fetch_o       = r_fetch;
    assign fetch_line_o  = r_fetch_line;
    assign frame_o       = r_frame;

`ifdef VIDEO_TIMING_SCANDOUBLE_EN
    assign repeat_o = r_repeat;
`else
    logic w_unused;
    assign w_unused = r_repeat;
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_video_timing_gen
//  Purpose  : Directed self-checking bench for video_timing_gen in a tiny
//             mode (H 8/2/2/2, V 4/1/1/1, FETCH_LEAD 3): line period 14,
//             frame period 98 pixels.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ce_i  = 1'b0;
    logic        hs_o, vs_o, de_o, line_start_o, frame_start_o, fetch_o;
    logic [10:0] x_o;
    logic [9:0]  y_o;
    logic [9:0]  fetch_line_o;
    logic [7:0]  frame_o;
`ifdef VIDEO_TIMING_SCANDOUBLE_EN
    logic        repeat_o;
`endif

    int checks = 0;
    int errors = 0;
    int n_edges = 0;   // ce edges since reset release
    int last_x = 0;
    int last_y = 0;

    always #5 clk_i = ~clk_i;

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(1), .FETCH_LEAD(3), .XW(11), .YW(10)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ce_i          (ce_i),
        .hs_o          (hs_o),
        .vs_o          (vs_o),
        .de_o          (de_o),
        .x_o           (x_o),
        .y_o           (y_o),
        .line_start_o  (line_start_o),
        .frame_start_o (frame_start_o),
        .fetch_o       (fetch_o),
        .fetch_line_o  (fetch_line_o),
        .frame_o       (frame_o)
`ifdef VIDEO_TIMING_SCANDOUBLE_EN
        ,
        .repeat_o      (repeat_o)
`endif
    );

    // Expected {de, hs, vs, line_start, frame_start, fetch} while pixel p
    // (0-based since reset) is presented.
    function automatic logic [5:0] exp_flags(input int p);
        int h, v;
        logic de, hs, vs, ls, fs, fe;
        h  = p % 14;
        v  = (p / 14) % 7;
        de = (h < 8) && (v < 4);
        hs = !((h >= 10) && (h < 12));
        vs = (v == 5);
        ls = de && (h == 0);
        fs = (h == 0) && (v == 0);
`ifdef VIDEO_TIMING_SCANDOUBLE_EN
        fe = (h == 11) && ((v == 6) || (v == 1));
`else
        fe = (h == 11) && ((v == 6) || (v < 3));
`endif
        return {de, hs, vs, ls, fs, fe};
    endfunction

    function automatic int exp_fetch_line(input int p);
        int v, row;
        v   = (p / 14) % 7;
        row = (v == 6) ? 0 : v + 1;
`ifdef VIDEO_TIMING_SCANDOUBLE_EN
        return row >> 1;
`else
        return row;
`endif
    endfunction

    task automatic advance(input logic ce);
        int p;
        ce_i = ce;
        @(posedge clk_i);
        #1;
        if (ce) begin
            n_edges++;
            p = n_edges - 1;
            if (((p % 14) < 8) && (((p / 14) % 7) < 4)) begin
                last_x = p % 14;
                last_y = (p / 14) % 7;
            end
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        ce_i  = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i   = 1'b0;
        n_edges = 0;
        last_x  = 0;
        last_y  = 0;
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        rst_i = 1'b1;
        ce_i  = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        obs = {de_o, hs_o, vs_o, line_start_o, frame_start_o, fetch_o};
        checks++;
        if (obs !== 6'b010000) begin
            errors++;
            $display("FAIL reset_flags got %b want %b", obs, 6'b010000);
        end
        checks++;
        if ({x_o, y_o, fetch_line_o, frame_o} !== 39'd0) begin
            errors++;
            $display("FAIL reset_values x=%0d y=%0d fl=%0d frame=%0d want all 0",
                     x_o, y_o, fetch_line_o, frame_o);
        end
        // Released with ce low: nothing may move.
        rst_i = 1'b0;
        ce_i  = 1'b0;
        n_edges = 0;
        last_x = 0;
        last_y = 0;
        repeat (3) @(posedge clk_i);
        #1;
        obs = {de_o, hs_o, vs_o, line_start_o, frame_start_o, fetch_o};
        checks++;
        if (obs !== 6'b010000 || x_o !== 11'd0 || y_o !== 10'd0) begin
            errors++;
            $display("FAIL reset_hold_ce0 flags %b want 010000 x=%0d y=%0d", obs, x_o, y_o);
        end
    endtask

    task automatic test_first_pixel();
        do_reset();
        advance(1'b1);
        checks++;
        if ({de_o, hs_o, vs_o, line_start_o, frame_start_o, fetch_o} !== 6'b110110
            || x_o !== 11'd0 || y_o !== 10'd0) begin
            errors++;
            $display("FAIL first_pixel flags %b want 110110 x=%0d y=%0d want 0,0",
                     {de_o, hs_o, vs_o, line_start_o, frame_start_o, fetch_o}, x_o, y_o);
        end
    endtask

    // One full frame plus one line with ce=1, every output checked per pixel.
    task automatic test_raster();
        logic [5:0] obs, exp;
        int p;
        do_reset();
        for (int e = 0; e < 112; e++) begin
            advance(1'b1);
            p   = n_edges - 1;
            obs = {de_o, hs_o, vs_o, line_start_o, frame_start_o, fetch_o};
            exp = exp_flags(p);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL raster_flags p=%0d got %b want %b", p, obs, exp);
            end
            checks++;
            if (x_o !== 11'(last_x) || y_o !== 10'(last_y)) begin
                errors++;
                $display("FAIL raster_xy p=%0d got %0d,%0d want %0d,%0d", p, x_o, y_o, last_x, last_y);
            end
            checks++;
            if (frame_o !== 8'((n_edges / 98) % 256)) begin
                errors++;
                $display("FAIL raster_frame p=%0d got %0d want %0d", p, frame_o, (n_edges / 98) % 256);
            end
            if (exp[0]) begin
                checks++;
                if (fetch_line_o !== 10'(exp_fetch_line(p))) begin
                    errors++;
                    $display("FAIL raster_fetch_line p=%0d got %0d want %0d",
                             p, fetch_line_o, exp_fetch_line(p));
                end
            end
`ifdef VIDEO_TIMING_SCANDOUBLE_EN
            if (exp[5]) begin
                checks++;
                if (repeat_o !== ((((p / 14) % 7) % 2) == 1)) begin
                    errors++;
                    $display("FAIL raster_repeat p=%0d got %b", p, repeat_o);
                end
            end
`endif
        end
    endtask

    task automatic test_frame_wrap();
        do_reset();
        while (n_edges < 98 * 255 - 1) advance(1'b1);
        checks++;
        if (frame_o !== 8'd254) begin
            errors++;
            $display("FAIL frame_254 got %0d want 254", frame_o);
        end
        advance(1'b1);
        checks++;
        if (frame_o !== 8'd255) begin
            errors++;
            $display("FAIL frame_255 got %0d want 255", frame_o);
        end
        while (n_edges < 98 * 256) advance(1'b1);
        checks++;
        if (frame_o !== 8'd0) begin
            errors++;
            $display("FAIL frame_wrap got %0d want 0", frame_o);
        end
        advance(1'b1);
        checks++;
        if (frame_start_o !== 1'b1 || frame_o !== 8'd0) begin
            errors++;
            $display("FAIL frame_wrap_start fs=%b frame=%0d want 1,0", frame_start_o, frame_o);
        end
    endtask

    // ce alternating 1/0: same sequence as ce=1, each value held for two clocks.
    task automatic test_ce_toggle();
        logic [5:0] obs, exp;
        int p;
        do_reset();
        for (int i = 0; i < 2 * 100; i++) begin
            advance((i % 2) == 0);
            p   = n_edges - 1;
            obs = {de_o, hs_o, vs_o, line_start_o, frame_start_o, fetch_o};
            exp = exp_flags(p);
            checks++;
            if (obs !== exp || x_o !== 11'(last_x) || y_o !== 10'(last_y)
                || frame_o !== 8'((n_edges / 98) % 256)) begin
                errors++;
                $display("FAIL ce_toggle i=%0d p=%0d flags %b want %b xy %0d,%0d want %0d,%0d frame %0d",
                         i, p, obs, exp, x_o, y_o, last_x, last_y, frame_o);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        while (n_edges < 98 + 34) advance(1'b1);   // pixel (5,2) of frame 1
        checks++;
        if (de_o !== 1'b1 || x_o !== 11'd5 || y_o !== 10'd2 || frame_o !== 8'd1) begin
            errors++;
            $display("FAIL async_pre de=%b x=%0d y=%0d frame=%0d want 1,5,2,1", de_o, x_o, y_o, frame_o);
        end
        #3;
        rst_i = 1'b1;
        #1;
        checks++;
        if ({de_o, hs_o, vs_o, line_start_o, frame_start_o, fetch_o} !== 6'b010000
            || x_o !== 11'd0 || y_o !== 10'd0 || frame_o !== 8'd0) begin
            errors++;
            $display("FAIL async_reset flags %b want 010000 x=%0d y=%0d frame=%0d want 0",
                     {de_o, hs_o, vs_o, line_start_o, frame_start_o, fetch_o}, x_o, y_o, frame_o);
        end
        @(posedge clk_i);
        #1;
        rst_i   = 1'b0;
        n_edges = 0;
        last_x  = 0;
        last_y  = 0;
        advance(1'b1);
        checks++;
        if ({de_o, hs_o, vs_o, line_start_o, frame_start_o, fetch_o} !== 6'b110110
            || x_o !== 11'd0 || y_o !== 10'd0) begin
            errors++;
            $display("FAIL async_restart flags %b want 110110 x=%0d y=%0d",
                     {de_o, hs_o, vs_o, line_start_o, frame_start_o, fetch_o}, x_o, y_o);
        end
        advance(1'b1);
        checks++;
        if (x_o !== 11'd1 || y_o !== 10'd0 || line_start_o !== 1'b0) begin
            errors++;
            $display("FAIL async_second x=%0d y=%0d ls=%b want 1,0,0", x_o, y_o, line_start_o);
        end
    endtask

    initial begin
        test_reset();
        test_first_pixel();
        test_raster();
        test_ce_toggle();
        test_async_reset();
        test_frame_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
